qpsk_symbol_packer: RTL and testbench

Downstream stage of the QPSK carrier-recovery / bit-sync path inside the RFNoC QPSK block. It consumes the 32-bit IQ AXI stream (I in [31:16], Q in [15:0]) together with the bit-sync strobe, and slices each strobed sample into a 2-bit hard decision. It packs the decisions MSB-first into 32-bit words and emits them as an AXI stream with packet framing, ready for the axi_wrapper output path.

---
 rtl/qpsk_symbol_packer.sv | 144 ++++++++++++++
 tb/tb_qpsk_symbol_packer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/qpsk_symbol_packer.sv
`default_nettype none
// =============================================================================
// Module   : qpsk_symbol_packer
// Brief    : Slices strobed IQ samples to QPSK dibits and packs them MSB-first
//            into framed 32-bit AXI-stream words. Define QPSK_PACK_DIFF_EN for
//            differential decoding.
// Revision : 1.0 - initial release
// =============================================================================
module qpsk_symbol_packer #(
    parameter int WORD_SYMS = 16
) (
    input  logic        ce_clk,
    input  logic        ce_rst,
    input  logic        clear,
    input  logic        sym_stb,
    input  logic [31:0] i_tdata,
    input  logic        i_tlast,
    input  logic        i_tvalid,
    output logic        i_tready,
    input  logic [15:0] pkt_len,
    output logic [31:0] o_tdata,
    output logic [4:0]  o_nsym,
    output logic        o_tlast,
    output logic        o_tvalid,
    input  logic        o_tready,
    output logic [31:0] sym_count
);

    localparam logic [4:0] c_WORD_SYMS = 5'(WORD_SYMS);

    logic [31:0] r_sh;
    logic [4:0]  r_cnt;
    logic [15:0] r_wcnt;
    logic [31:0] r_tdata;
    logic [4:0]  r_nsym;
    logic        r_tlast;
    logic        r_tvalid;
    logic [31:0] r_sym_count;

    logic        w_accept;
    logic        w_sym;
    logic [1:0]  w_dibit;
    logic [31:0] w_ins;
    logic [31:0] w_sh_next;
    logic [4:0]  w_cnt_next;
    logic        w_full;
    logic        w_flush;
    logic        w_load;
    logic        w_empty_last;
    logic        w_len_last;
    logic        w_tlast_out;
    logic        w_unused;

    assign i_tready  = !r_tvalid || o_tready;
    assign w_accept  = i_tvalid && i_tready;
    assign w_sym     = w_accept && sym_stb;
    assign w_unused  = ^{i_tdata[30:16], i_tdata[14:0]};

`ifdef QPSK_PACK_DIFF_EN
    logic [1:0] w_phase;
    logic [1:0] r_p_prev;

    // Quadrant index 0..3 counter-clockwise from (+,+).
    assign w_phase = {i_tdata[15], i_tdata[31] ^ i_tdata[15]};
    assign w_dibit = w_phase - r_p_prev;

    always_ff @(posedge ce_clk or posedge ce_rst) begin
        if (ce_rst) begin
            r_p_prev <= 2'd0;
        end else if (clear) begin
            r_p_prev <= 2'd0;
        end else if (w_sym) begin
            r_p_prev <= w_phase;
        end
    end
`else
    assign w_dibit = {i_tdata[31], i_tdata[15]};
`endif

    // Dibit lands at [31-2*cnt -: 2]; cnt never reaches WORD_SYMS here.
    assign w_ins        = {w_dibit, 30'd0} >> {r_cnt, 1'b0};
    assign w_sh_next    = w_sym ? (r_sh | w_ins) : r_sh;
    assign w_cnt_next   = r_cnt + {4'd0, w_sym};
    assign w_full       = w_sym && (w_cnt_next == c_WORD_SYMS);
    assign w_flush      = w_accept && i_tlast && (w_cnt_next != 5'd0);
    assign w_load       = w_full || w_flush;
    assign w_empty_last = w_accept && i_tlast && (w_cnt_next == 5'd0);
    assign w_len_last   = (pkt_len != 16'd0) && (r_wcnt == pkt_len - 16'd1);
    assign w_tlast_out  = w_flush || w_len_last;

    always_ff @(posedge ce_clk or posedge ce_rst) begin
        if (ce_rst) begin
            r_sh        <= 32'd0;
            r_cnt       <= 5'd0;
            r_wcnt      <= 16'd0;
            r_tdata     <= 32'd0;
            r_nsym      <= 5'd0;
            r_tlast     <= 1'b0;
            r_tvalid    <= 1'b0;
            r_sym_count <= 32'd0;
        end else if (clear) begin
            r_sh        <= 32'd0;
            r_cnt       <= 5'd0;
            r_wcnt      <= 16'd0;
            r_tdata     <= 32'd0;
            r_nsym      <= 5'd0;
            r_tlast     <= 1'b0;
            r_tvalid    <= 1'b0;
            r_sym_count <= 32'd0;
        end else begin
            if (w_sym) begin
                r_sym_count <= r_sym_count + 32'd1;
            end

            if (w_load) begin
                r_sh     <= 32'd0;
                r_cnt    <= 5'd0;
                r_tdata  <= w_sh_next;
                r_nsym   <= w_cnt_next;
                r_tlast  <= w_tlast_out;
                r_tvalid <= 1'b1;
                r_wcnt   <= w_tlast_out ? 16'd0 : r_wcnt + 16'd1;
            end else begin
                r_sh  <= w_sh_next;
                r_cnt <= w_cnt_next;
                if (o_tready) begin
                    r_tvalid <= 1'b0;
                end
                // A bare tlast still closes the packet for length framing.
                if (w_empty_last) begin
                    r_wcnt <= 16'd0;
                end
            end
        end
    end

    assign o_tdata   = r_tdata;
    assign o_nsym    = r_nsym;
    assign o_tlast   = r_tlast;
    assign o_tvalid  = r_tvalid;
    assign sym_count = r_sym_count;

endmodule
`default_nettype wire

// File: tb/tb_qpsk_symbol_packer.sv
`default_nettype none
// =============================================================================
// Module   : tb_qpsk_symbol_packer
// Brief    : Directed, table-driven self-checking bench for qpsk_symbol_packer.
// Revision : 1.0 - initial release
// =============================================================================
module tb_qpsk_symbol_packer;

    localparam logic [15:0] c_POS = 16'h4000;
    localparam logic [15:0] c_NEG = 16'hC000;

    logic        ce_clk = 1'b0;
    logic        ce_rst;
    logic        clear;
    logic        sym_stb;
    logic [31:0] i_tdata;
    logic        i_tlast;
    logic        i_tvalid;
    logic        i_tready;
    logic [15:0] pkt_len;
    logic [31:0] o_tdata;
    logic [4:0]  o_nsym;
    logic        o_tlast;
    logic        o_tvalid;
    logic        o_tready;
    logic [31:0] sym_count;

    qpsk_symbol_packer #(.WORD_SYMS(16)) dut (
        .ce_clk    (ce_clk),
        .ce_rst    (ce_rst),
        .clear     (clear),
        .sym_stb   (sym_stb),
        .i_tdata   (i_tdata),
        .i_tlast   (i_tlast),
        .i_tvalid  (i_tvalid),
        .i_tready  (i_tready),
        .pkt_len   (pkt_len),
        .o_tdata   (o_tdata),
        .o_nsym    (o_nsym),
        .o_tlast   (o_tlast),
        .o_tvalid  (o_tvalid),
        .o_tready  (o_tready),
        .sym_count (sym_count)
    );

    always #5 ce_clk = ~ce_clk;

    typedef struct {
        int          n;
        logic [15:0] i;
        logic [15:0] q;
        logic        last;
        logic [31:0] d;
        logic [4:0]  nsym;
        logic        tl;
    } vec_t;

    vec_t vt[7];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge ce_clk);
        #1;
    endtask

    task automatic beat(input logic stb, input logic [15:0] i, input logic [15:0] q, input logic last);
        sym_stb  = stb;
        i_tdata  = {i, q};
        i_tlast  = last;
        i_tvalid = 1'b1;
        step();
        i_tvalid = 1'b0;
        sym_stb  = 1'b0;
        i_tlast  = 1'b0;
    endtask

    task automatic burst(input int n, input logic [15:0] i, input logic [15:0] q);
        for (int k = 0; k < n; k++) beat(1'b1, i, q, 1'b0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    initial begin
        int words;

        ce_rst = 1'b1; clear = 1'b0; sym_stb = 1'b0; i_tdata = 32'd0;
        i_tlast = 1'b0; i_tvalid = 1'b0; pkt_len = 16'd0; o_tready = 1'b1;
        step();
        step();
        chk("rst_i_tready",  {31'd0, i_tready}, 32'd1);
        chk("rst_o_tvalid",  {31'd0, o_tvalid}, 32'd0);
        chk("rst_o_tdata",   o_tdata, 32'd0);
        chk("rst_o_nsym",    {27'd0, o_nsym}, 32'd0);
        chk("rst_o_tlast",   {31'd0, o_tlast}, 32'd0);
        chk("rst_sym_count", sym_count, 32'd0);
        ce_rst = 1'b0;
        step();

`ifdef QPSK_PACK_DIFF_EN
        // Phases 0,1,3,3 -> dibits 00,01,10,00
        beat(1'b1, c_POS, c_POS, 1'b0);
        beat(1'b1, c_NEG, c_POS, 1'b0);
        beat(1'b1, c_POS, c_NEG, 1'b0);
        beat(1'b1, c_POS, c_NEG, 1'b1);
        chk("diff1_valid", {31'd0, o_tvalid}, 32'd1);
        chk("diff1_data",  o_tdata, 32'h18000000);
        chk("diff1_nsym",  {27'd0, o_nsym}, 32'd4);
        chk("diff1_tlast", {31'd0, o_tlast}, 32'd1);
        step();
        // p_prev survives tlast: phases 2,2,0 -> 11,00,10
        beat(1'b1, c_NEG, c_NEG, 1'b0);
        beat(1'b1, c_NEG, c_NEG, 1'b0);
        beat(1'b1, c_POS, c_POS, 1'b1);
        chk("diff2_data", o_tdata, 32'hC8000000);
        chk("diff2_nsym", {27'd0, o_nsym}, 32'd3);
        step();
        beat(1'b1, c_NEG, c_POS, 1'b0);
        beat(1'b1, c_NEG, c_POS, 1'b0);
        ce_rst = 1'b1;
        #1;
        chk("drst_o_tvalid",  {31'd0, o_tvalid}, 32'd0);
        chk("drst_o_tdata",   o_tdata, 32'd0);
        chk("drst_o_nsym",    {27'd0, o_nsym}, 32'd0);
        chk("drst_sym_count", sym_count, 32'd0);
        chk("drst_i_tready",  {31'd0, i_tready}, 32'd1);
        step();
        ce_rst = 1'b0;
        step();
        chk("drst_no_emit", {31'd0, o_tvalid}, 32'd0);
        beat(1'b1, c_NEG, c_POS, 1'b1);
        chk("diff3_data", o_tdata, 32'h40000000);
        chk("diff3_nsym", {27'd0, o_nsym}, 32'd1);
        step();
`else
        vt[0] = '{16, c_POS, c_NEG, 1'b0, 32'h55555555, 5'd16, 1'b0};
        vt[1] = '{5,  c_NEG, c_NEG, 1'b1, 32'hFFC00000, 5'd5,  1'b1};
        vt[2] = '{16, c_NEG, c_POS, 1'b0, 32'hAAAAAAAA, 5'd16, 1'b0};
        vt[3] = '{1,  c_POS, c_POS, 1'b1, 32'h00000000, 5'd1,  1'b1};
        vt[4] = '{3,  c_NEG, c_POS, 1'b1, 32'hA8000000, 5'd3,  1'b1};
        vt[5] = '{16, c_NEG, c_NEG, 1'b1, 32'hFFFFFFFF, 5'd16, 1'b1};
        vt[6] = '{2,  c_POS, c_NEG, 1'b1, 32'h50000000, 5'd2,  1'b1};

        for (int v = 0; v < 7; v++) begin
            for (int k = 0; k < vt[v].n; k++) begin
                if (k == vt[v].n - 1) chk($sformatf("v%0d_pre_valid", v), {31'd0, o_tvalid}, 32'd0);
                beat(1'b1, vt[v].i, vt[v].q, vt[v].last && (k == vt[v].n - 1));
            end
            chk($sformatf("v%0d_valid", v), {31'd0, o_tvalid}, 32'd1);
            chk($sformatf("v%0d_data", v),  o_tdata, vt[v].d);
            chk($sformatf("v%0d_nsym", v),  {27'd0, o_nsym}, {27'd0, vt[v].nsym});
            chk($sformatf("v%0d_tlast", v), {31'd0, o_tlast}, {31'd0, vt[v].tl});
            step();
        end
        chk("table_sym_count", sym_count, 32'd59);

        // Clear wins over a simultaneous strobed beat
        clear = 1'b1; sym_stb = 1'b1; i_tvalid = 1'b1; i_tdata = {c_NEG, c_NEG};
        step();
        clear = 1'b0; sym_stb = 1'b0; i_tvalid = 1'b0;
        chk("clear_sym_count", sym_count, 32'd0);
        chk("clear_o_tdata", o_tdata, 32'd0);

        // Bare tlast emits nothing but restarts length framing
        pkt_len = 16'd2;
        burst(16, c_POS, c_NEG);
        chk("len2_w0_tlast", {31'd0, o_tlast}, 32'd0);
        step();
        beat(1'b0, c_NEG, c_NEG, 1'b1);
        chk("bare_tlast_no_emit", {31'd0, o_tvalid}, 32'd0);
        step();
        burst(16, c_POS, c_NEG);
        chk("len2_restart_tlast", {31'd0, o_tlast}, 32'd0);
        step();
        burst(16, c_POS, c_NEG);
        chk("len2_w1_tlast", {31'd0, o_tlast}, 32'd1);
        step();

        // Length framing, back-to-back symbols
        do_clear();
        pkt_len = 16'd3;
        words = 0;
        for (int k = 0; k < 96; k++) begin
            beat(1'b1, c_NEG, c_NEG, 1'b0);
            if (o_tvalid) begin
                words++;
                chk($sformatf("len3_w%0d_tlast", words), {31'd0, o_tlast}, {31'd0, (words % 3) == 0});
            end
        end
        step();
        chk("len3_words", words, 32'd6);
        pkt_len = 16'd0;

        // Sparse strobe
        do_clear();
        words = 0;
        for (int k = 0; k < 512; k++) begin
            beat((k % 16) == 15, c_POS, c_NEG, 1'b0);
            if (o_tvalid) words++;
        end
        step();
        chk("sparse_words", words, 32'd2);
        chk("sparse_sym_count", sym_count, 32'd32);

        // Backpressure across a word completion
        do_clear();
        o_tready = 1'b0;
        burst(16, c_POS, c_NEG);
        chk("stall_valid", {31'd0, o_tvalid}, 32'd1);
        chk("stall_i_tready", {31'd0, i_tready}, 32'd0);
        sym_stb = 1'b1; i_tvalid = 1'b1; i_tdata = {c_NEG, c_NEG};
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("stall_data_%0d", k), o_tdata, 32'h55555555);
            chk($sformatf("stall_ready_%0d", k), {31'd0, i_tready}, 32'd0);
        end
        o_tready = 1'b1;
        #1;
        chk("release_i_tready", {31'd0, i_tready}, 32'd1);
        step();
        sym_stb = 1'b0; i_tvalid = 1'b0;
        chk("release_drained", {31'd0, o_tvalid}, 32'd0);
        chk("release_sym_count", sym_count, 32'd17);
        burst(15, c_NEG, c_NEG);
        chk("after_stall_data", o_tdata, 32'hFFFFFFFF);
        step();

        // Reset mid-word discards the partial word
        burst(5, c_NEG, c_POS);
        ce_rst = 1'b1;
        #1;
        chk("mrst_o_tvalid",  {31'd0, o_tvalid}, 32'd0);
        chk("mrst_o_tdata",   o_tdata, 32'd0);
        chk("mrst_o_nsym",    {27'd0, o_nsym}, 32'd0);
        chk("mrst_o_tlast",   {31'd0, o_tlast}, 32'd0);
        chk("mrst_sym_count", sym_count, 32'd0);
        chk("mrst_i_tready",  {31'd0, i_tready}, 32'd1);
        step();
        ce_rst = 1'b0;
        step();
        chk("mrst_no_emit", {31'd0, o_tvalid}, 32'd0);
        beat(1'b1, c_NEG, c_NEG, 1'b1);
        chk("mrst_next_data", o_tdata, 32'hC0000000);
        chk("mrst_next_nsym", {27'd0, o_nsym}, 32'd1);
        step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
